// File: rtl/regbank_write_arbiter.sv
// Round-robin write arbiter for a bank of enable-gated registers.
// Several requesters share one write path. Each accepted write produces a one-hot register
// enable and the write data, both valid for exactly one cycle. One owner may keep the path
// for at most MAXBURST consecutive writes while another requester is waiting.
module regbank_write_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NREG     = 8,
    parameter int unsigned AW       = 3,
    parameter int unsigned MAXBURST = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_hold,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*AW-1:0]    i_wr_addr,
    input  logic [NREQ*WIDTH-1:0] i_wr_data,
    output logic [NREQ-1:0]       o_gnt,
    output logic [NREG-1:0]       o_reg_en,
    output logic [WIDTH-1:0]      o_reg_d,
    output logic                  o_addr_err,
    output logic                  o_busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BW = $clog2(MAXBURST + 1);
    localparam logic [BW-1:0]   BMAX     = BW'(MAXBURST);
    localparam logic [AW:0]     NREG_LIM = (AW + 1)'(NREG);
    localparam logic [NREQ-1:0] ONE_REQ  = NREQ'(1);

    typedef enum logic {StIdle, StOwn} state_t;

    state_t           r_state;
    logic [PW-1:0]    r_owner;
    logic [BW-1:0]    r_burst_cnt;
    logic [PW-1:0]    r_rr_ptr;
    logic [NREQ-1:0]  r_gnt;
    logic [NREG-1:0]  r_reg_en;
    logic [WIDTH-1:0] r_reg_d;
    logic             r_addr_err;
    logic             r_busy;

    state_t           w_state_d;
    logic [PW-1:0]    w_owner_d;
    logic [BW-1:0]    w_burst_d;
    logic [PW-1:0]    w_ptr_d;
    logic             w_accept;
    logic [PW-1:0]    w_sel;
    logic [NREQ-1:0]  w_others;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_data;
    logic             w_addr_bad;
    logic [NREG-1:0]  w_en_dec;

    // Next index after p, wrapping NREQ-1 -> 0.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NREQ - 1)) ? '0 : p + PW'(1);
    endfunction

    // First set bit of r scanning p, p+1, ... modulo NREQ.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] win;
        logic          found;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            int idx;
            idx = (int'(p) + k) % int'(NREQ);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        return win;
    endfunction

    // Arbitration: decide whether to accept this edge, who wins, and the next FSM state.
    always_comb begin
        w_state_d = r_state;
        w_owner_d = r_owner;
        w_burst_d = r_burst_cnt;
        w_ptr_d   = r_rr_ptr;
        w_accept  = 1'b0;
        w_sel     = r_owner;
        w_others  = i_req & ~(ONE_REQ << r_owner);
        if (!i_hold) begin
            unique case (r_state)
                StIdle: begin
                    if (|i_req) begin
                        w_accept  = 1'b1;
                        w_sel     = rr_pick(i_req, r_rr_ptr);
                        w_owner_d = w_sel;
                        w_burst_d = BW'(1);
                        w_state_d = StOwn;
                    end
                end
                StOwn: begin
                    if (i_req[r_owner] && ((r_burst_cnt < BMAX) || (w_others == '0))) begin
                        w_accept = 1'b1;
                        w_sel    = r_owner;
                        if (r_burst_cnt < BMAX) begin
                            w_burst_d = r_burst_cnt + BW'(1);
                        end
                    end else begin
                        // Owner released or burst exhausted: pass ownership on this edge.
                        w_ptr_d = ptr_inc(r_owner);
                        if (|w_others) begin
                            w_accept  = 1'b1;
                            w_sel     = rr_pick(w_others, ptr_inc(r_owner));
                            w_owner_d = w_sel;
                            w_burst_d = BW'(1);
                        end else begin
                            w_state_d = StIdle;
                        end
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Select the winner's address/data and decode the register enable.
    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_sel == PW'(i)) begin
                w_addr = i_wr_addr[i*AW +: AW];
                w_data = i_wr_data[i*WIDTH +: WIDTH];
            end
        end
        w_addr_bad = ({1'b0, w_addr} >= NREG_LIM);
        w_en_dec   = '0;
        for (int k = 0; k < int'(NREG); k++) begin
            w_en_dec[k] = (w_addr == AW'(k));
        end
    end

    // FSM state, ownership, burst count and round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state     <= w_state_d;
            r_owner     <= w_owner_d;
            r_burst_cnt <= w_burst_d;
            r_rr_ptr    <= w_ptr_d;
        end
    end

    // Registered outputs; reg_d keeps its last value when nothing is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt      <= '0;
            r_reg_en   <= '0;
            r_reg_d    <= '0;
            r_addr_err <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_gnt      <= w_accept ? (ONE_REQ << w_sel) : '0;
            r_reg_en   <= (w_accept && !w_addr_bad) ? w_en_dec : '0;
            r_addr_err <= w_accept && w_addr_bad;
            r_busy     <= (w_state_d == StOwn);
            if (w_accept) begin
                r_reg_d <= w_data;
            end
        end
    end

    assign o_gnt      = r_gnt;
    assign o_reg_en   = r_reg_en;
    assign o_reg_d    = r_reg_d;
    assign o_addr_err = r_addr_err;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter.
// Three instances share stimulus: default config (a), MAXBURST=1 (b), NREG=6 (c).
module tb_regbank_write_arbiter;

    localparam int AW    = 3;
    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic [3:0]  req = '0;
    logic [11:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic [7:0] en_a, en_b;
    logic [5:0] en_c;
    logic [7:0] d_a, d_b, d_c;
    logic       err_a, err_b, err_c;
    logic       busy_a, busy_b, busy_c;

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0] exp_a [8];
    logic [3:0] exp_b [8];

    regbank_write_arbiter #(.NREQ(4), .WIDTH(8), .NREG(8), .AW(3), .MAXBURST(4)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .i_req(req),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_gnt(gnt_a), .o_reg_en(en_a), .o_reg_d(d_a), .o_addr_err(err_a), .o_busy(busy_a)
    );

    regbank_write_arbiter #(.NREQ(4), .WIDTH(8), .NREG(8), .AW(3), .MAXBURST(1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .i_req(req),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_gnt(gnt_b), .o_reg_en(en_b), .o_reg_d(d_b), .o_addr_err(err_b), .o_busy(busy_b)
    );

    regbank_write_arbiter #(.NREQ(4), .WIDTH(8), .NREG(6), .AW(3), .MAXBURST(4)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .i_req(req),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_gnt(gnt_c), .o_reg_en(en_c), .o_reg_d(d_c), .o_addr_err(err_c), .o_busy(busy_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int i, input logic [2:0] a, input logic [7:0] d);
        wr_addr[i*AW +: AW]       = a;
        wr_data[i*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        exp_a = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2};
        exp_b = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};

        // Power-on reset
        step();
        step();
        chk("rst_gnt", gnt_a, 0);
        chk("rst_en", en_a, 0);
        chk("rst_d", d_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_busy", busy_a, 0);
        rst_n = 1'b1;

        // Single write, then release
        set_wr(0, 3'd5, 8'hA5);
        req = 4'b0001;
        step();
        chk("single_gnt", gnt_a, 4'b0001);
        chk("single_en", en_a, 8'b0010_0000);
        chk("single_d", d_a, 8'hA5);
        chk("single_busy", busy_a, 1);
        chk("single_err", err_a, 0);
        req = 4'b0000;
        step();
        chk("drop_gnt", gnt_a, 0);
        chk("drop_en", en_a, 0);
        chk("drop_d_hold", d_a, 8'hA5);
        chk("drop_busy", busy_a, 0);

        // hold overrides a pending request
        set_wr(1, 3'd2, 8'h3C);
        req  = 4'b0010;
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_gnt", gnt_a, 0);
            chk("hold_busy", busy_a, 0);
        end
        hold = 1'b0;
        step();
        chk("unhold_gnt", gnt_a, 4'b0010);
        chk("unhold_en", en_a, 8'b0000_0100);
        chk("unhold_d", d_a, 8'h3C);
        req = 4'b0000;
        step();
        chk("unhold_drop", gnt_a, 0);

        // Burst limit: req0 x4 then req2, then req0 again
        set_wr(0, 3'd1, 8'h11);
        set_wr(2, 3'd6, 8'h22);
        req = 4'b0001;
        step();
        chk("burst_first", gnt_a, 4'b0001);
        chk("burst_first_en", en_a, 8'b0000_0010);
        req = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("burst_own", gnt_a, 4'b0001);
        end
        step();
        chk("burst_switch", gnt_a, 4'b0100);
        chk("burst_switch_en", en_a, 8'b0100_0000);
        chk("burst_switch_d", d_a, 8'h22);
        chk("burst_busy", busy_a, 1);
        req = 4'b0001;
        step();
        chk("burst_back", gnt_a, 4'b0001);
        chk("burst_back_d", d_a, 8'h11);
        req = 4'b0000;
        step();
        chk("burst_idle_gnt", gnt_a, 0);
        chk("burst_idle_busy", busy_a, 0);

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 4; i++) set_wr(i, 3'(i), 8'(8'h10 + i));
        req = 4'b1111;
        step();
        step();
        chk("pre_rst_busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", gnt_a, 0);
        chk("arst_en", en_a, 0);
        chk("arst_d", d_a, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_gnt_b", gnt_b, 0);
        step();
        chk("arst_held", gnt_a, 0);
        rst_n = 1'b1;

        // First accept after release is req0; then round-robin / burst order
        for (int k = 0; k < 8; k++) begin
            step();
            chk("order_a", gnt_a, exp_a[k]);
            chk("rr_b", gnt_b, exp_b[k]);
            chk("rr_b_d", d_b, 8'(8'h10 + (k % 4)));
        end

        // Address range check on the NREG=6 instance
        req = 4'b0000;
        step();
        chk("ae_idle", gnt_c, 0);
        set_wr(1, 3'd7, 8'h5A);
        req = 4'b0010;
        step();
        chk("ae_gnt", gnt_c, 4'b0010);
        chk("ae_en", en_c, 0);
        chk("ae_err", err_c, 1);
        chk("ae_d", d_c, 8'h5A);
        chk("ae_en_a", en_a, 8'b1000_0000);
        chk("ae_err_a", err_a, 0);
        set_wr(1, 3'd5, 8'h5B);
        step();
        chk("ae_ok_gnt", gnt_c, 4'b0010);
        chk("ae_ok_en", en_c, 6'b10_0000);
        chk("ae_ok_err", err_c, 0);
        set_wr(1, 3'd6, 8'h5C);
        step();
        chk("ae_edge_en", en_c, 0);
        chk("ae_edge_err", err_c, 1);
        chk("ae_edge_d", d_c, 8'h5C);
        req = 4'b0000;
        step();
        chk("ae_end_gnt", gnt_c, 0);
        chk("ae_end_err", err_c, 0);
        chk("ae_end_en", en_c, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
